eae_unit: RTL

//  Extended Arithmetic Element (EAE) for the PDP-8 core.
//  - Executes MUY (multiply) and DVI (divide) as multi-cycle operations on request from the controller.
//  - Sits directly upstream of the CPU datapath. It drives the bus results ac_mul, mq_mul, ac_dvi,
//    mq_dvi and link_dvi, which the datapath loads under AC_MUL/AC_DVI, MQ_MUL/MQ_DVI and LK_DVI.
//  - Operands are curr_reg.ac, curr_reg.mq and curr_reg.mb, sampled on start.

---
 rtl/eae_unit_if.sv | 25 ++
 rtl/eae_unit.sv | 136 +++++++++++++
 2 files changed

// File: rtl/eae_unit_if.sv
// Request/result bundle between the PDP-8 controller/datapath and the EAE.
// The controller drives the request side; the EAE drives status and result words.
interface eae_unit_if #(parameter int WIDTH = 12);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] ac_in;
  logic [WIDTH-1:0] mq_in;
  logic [WIDTH-1:0] operand;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ac_mul;
  logic [WIDTH-1:0] mq_mul;
  logic [WIDTH-1:0] ac_dvi;
  logic [WIDTH-1:0] mq_dvi;
  logic             link_dvi;

  modport master (
    output start, op, ac_in, mq_in, operand,
    input  busy, done, ac_mul, mq_mul, ac_dvi, mq_dvi, link_dvi
  );
  modport slave (
    input  start, op, ac_in, mq_in, operand,
    output busy, done, ac_mul, mq_mul, ac_dvi, mq_dvi, link_dvi
  );
endinterface

// File: rtl/eae_unit.sv
// PDP-8 EAE: multi-cycle MUY (shift-add) and DVI (restoring divide), one bit per cycle.
// Define EAE_MUY_ACCUM_EN to make MUY add AC into the product (PDP-8/E semantics).
module eae_unit #(
  parameter int WIDTH = 12
) (
  input  logic       clock,
  input  logic       resetN,
  eae_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t               state;
  logic [3:0]           cnt;
  logic                 busy_q, done_q, link_q;
  logic [WIDTH-1:0]     ac_mul_q, mq_mul_q, ac_dvi_q, mq_dvi_q;

  // MUY working set: accumulator, left-shifting multiplicand, right-shifting multiplier
  logic [2*WIDTH:0]     acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;

  // DVI working set: partial remainder, dividend-low/quotient shifter, divisor
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     divisor;

  logic [2*WIDTH:0]     acc_nxt;
  logic [WIDTH:0]       rem_sh, rem_nxt;
  logic [WIDTH-1:0]     quo_nxt;
  logic                 last;
  logic [1:0]           unused_bits;

  always_comb begin
    acc_nxt = mplier[0] ? acc + {1'b0, mcand} : acc;
    rem_sh  = {rem, quo[WIDTH-1]};
    rem_nxt = rem_sh;
    quo_nxt = {quo[WIDTH-2:0], 1'b0};
    if (rem_sh >= {1'b0, divisor}) begin
      rem_nxt = rem_sh - {1'b0, divisor};
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end
  end

  assign last = (cnt == 4'(WIDTH-1));
  // Top bits cannot be set: product fits 2*WIDTH, remainder stays below divisor.
  assign unused_bits = {acc_nxt[2*WIDTH], rem_nxt[WIDTH]};

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      link_q   <= 1'b0;
      ac_mul_q <= '0;
      mq_mul_q <= '0;
      ac_dvi_q <= '0;
      mq_dvi_q <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          cnt    <= '0;
          busy_q <= 1'b1;
          if (!bus.op) begin
            state  <= MUL;
`ifdef EAE_MUY_ACCUM_EN
            acc    <= {{(WIDTH+1){1'b0}}, bus.ac_in};
`else
            acc    <= '0;
`endif
            mcand  <= {{WIDTH{1'b0}}, bus.operand};
            mplier <= bus.mq_in;
          end else if (bus.ac_in < bus.operand) begin
            state   <= DIV;
            rem     <= bus.ac_in;
            quo     <= bus.mq_in;
            divisor <= bus.operand;
          end else begin
            // Quotient would not fit (includes divide by zero): report and pass AC/MQ through
            state    <= DONE;
            done_q   <= 1'b1;
            ac_dvi_q <= bus.ac_in;
            mq_dvi_q <= bus.mq_in;
            link_q   <= 1'b1;
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
          if (last) begin
            state    <= DONE;
            done_q   <= 1'b1;
            ac_mul_q <= acc_nxt[2*WIDTH-1:WIDTH];
            mq_mul_q <= acc_nxt[WIDTH-1:0];
          end
        end
        DIV: begin
          rem <= rem_nxt[WIDTH-1:0];
          quo <= quo_nxt;
          cnt <= cnt + 4'd1;
          if (last) begin
            state    <= DONE;
            done_q   <= 1'b1;
            ac_dvi_q <= rem_nxt[WIDTH-1:0];
            mq_dvi_q <= quo_nxt;
            link_q   <= 1'b0;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ac_mul   = ac_mul_q;
  assign bus.mq_mul   = mq_mul_q;
  assign bus.ac_dvi   = ac_dvi_q;
  assign bus.mq_dvi   = mq_dvi_q;
  assign bus.link_dvi = link_q;

endmodule
